// File: rtl/par_parameter.sv
// Shared datapath sizing for the par-sized MAC/divider slice.
// W is the operand width; DW holds a full MAC product word.
package par_parameter;

    localparam int par = 3;
    localparam int W   = par + 1;
    localparam int DW  = 2 * W;
    localparam int CW  = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

endpackage

// File: rtl/mac_divider_if.sv
// Start/busy/done handshake and operand/result buses for mac_divider.
interface mac_divider_if;
    import par_parameter::*;

    logic          start;
    logic [DW-1:0] DIVIDEND;
    logic [W-1:0]  DIVISOR;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [DW-1:0] QUOT;
    logic [W-1:0]  REM;

    modport master (
        output start, DIVIDEND, DIVISOR,
        input  busy, done, div_by_zero, QUOT, REM
    );

    modport slave (
        input  start, DIVIDEND, DIVISOR,
        output busy, done, div_by_zero, QUOT, REM
    );

endinterface

// File: rtl/mac_divider.sv
// Restoring divider, one quotient bit per clock: splits a MAC result A*B+C
// back into QUOT=A and REM=C for a known divisor B.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one shift/compare/subtract step per clock
// DONE  | one-cycle done pulse, then back to IDLE
module mac_divider
    import par_parameter::*;
(
    input  logic          clk,
    input  logic          reset,
    mac_divider_if.slave  bus
);

    div_state_t    state, state_nxt;
    logic [DW-1:0] dvd;
    logic [W-1:0]  dsr;
    logic [W-1:0]  prem;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quot;
    logic [W-1:0]  rem;
    logic          dbz;

    logic [W:0]    trial;
    logic          qbit;
    logic [W:0]    rem_step;
    logic          busy_o;
    logic          done_o;

    // Trial remainder carries one extra bit so the compare cannot wrap.
    always_comb begin
        trial    = {prem, dvd[DW-1]};
        qbit     = (trial >= {1'b0, dsr});
        rem_step = qbit ? (trial - {1'b0, dsr}) : trial;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start)
                      state_nxt = (bus.DIVISOR == '0) ? DONE : RUN;
            RUN:  if (cnt == '0)
                      state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            RUN:  busy_o = 1'b1;
            DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd  <= '0;
            dsr  <= '0;
            prem <= '0;
            cnt  <= '0;
            quot <= '0;
            rem  <= '0;
            dbz  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    dvd  <= bus.DIVIDEND;
                    dsr  <= bus.DIVISOR;
                    prem <= '0;
                    cnt  <= CW'(DW - 1);
                    dbz  <= 1'b0;
                    // Zero divisor short-circuits straight to DONE with saturated results.
                    if (bus.DIVISOR == '0) begin
                        quot <= '1;
                        rem  <= bus.DIVIDEND[W-1:0];
                        dbz  <= 1'b1;
                    end
                end
                RUN: begin
                    prem <= rem_step[W-1:0];
                    dvd  <= {dvd[DW-2:0], qbit};
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quot <= {dvd[DW-2:0], qbit};
                        rem  <= rem_step[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_o;
    assign bus.done        = done_o;
    assign bus.div_by_zero = dbz;
    assign bus.QUOT        = quot;
    assign bus.REM         = rem;

endmodule

// File: tb/tb_mac_divider.sv
// Scoreboard bench for mac_divider: expected results queued at issue time,
// popped and compared when done pulses.
module tb_mac_divider;
    import par_parameter::*;

    typedef struct {
        logic [DW-1:0] q;
        logic [W-1:0]  r;
        logic          z;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_divider_if bus ();

    mac_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Drive one start cycle from IDLE and queue the arithmetic expectation.
    task automatic issue(input logic [DW-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a[W-1:0]; e.z = 1'b1; e.lat = 0;
        end else begin
            e.q = a / b; e.r = W'(a % b); e.z = 1'b0; e.lat = DW;
        end
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1; bus.DIVIDEND = a; bus.DIVISOR = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.DIVIDEND = DW'($urandom); bus.DIVISOR = W'($urandom);
    endtask

    // Called at the negedge after the accept edge; lat counts edges after it.
    task automatic wait_done(output int lat, output int nbusy);
        lat = 0; nbusy = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); else n_pass++;
        n_total++; if (bus.QUOT !== '0) $display("FAIL reset_quot got=%h want=0", bus.QUOT); else n_pass++;
        n_total++; if (bus.REM !== '0) $display("FAIL reset_rem got=%h want=0", bus.REM); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, nb; exp_t e;
        issue(8'd47, 4'd5);
        n_total++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_early got=%b want=1", bus.busy); else n_pass++;
        wait_done(lat, nb);
        e = sb.pop_front();
        n_total++; if (lat != e.lat) $display("FAIL basic_latency got=%0d want=%0d", lat, e.lat); else n_pass++;
        n_total++; if (nb != DW) $display("FAIL basic_busy_cycles got=%0d want=%0d", nb, DW); else n_pass++;
        n_total++; if (bus.QUOT !== 8'd9 || bus.QUOT !== e.q) $display("FAIL basic_quot got=%0d want=9", bus.QUOT); else n_pass++;
        n_total++; if (bus.REM !== 4'd2 || bus.REM !== e.r) $display("FAIL basic_rem got=%0d want=2", bus.REM); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL basic_dbz got=%b want=0", bus.div_by_zero); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got=%b want=0", bus.done); else n_pass++;
        n_total++; if (bus.QUOT !== 8'd9) $display("FAIL basic_quot_hold got=%0d want=9", bus.QUOT); else n_pass++;
    endtask

    task automatic test_div_zero();
        int lat, nb; exp_t e;
        issue(8'd200, 4'd0);
        wait_done(lat, nb);
        e = sb.pop_front();
        n_total++; if (lat != e.lat) $display("FAIL dz_latency got=%0d want=%0d", lat, e.lat); else n_pass++;
        n_total++; if (bus.div_by_zero !== e.z) $display("FAIL dz_flag got=%b want=%b", bus.div_by_zero, e.z); else n_pass++;
        n_total++; if (bus.QUOT !== 8'hFF) $display("FAIL dz_quot got=%h want=ff", bus.QUOT); else n_pass++;
        n_total++; if (bus.REM !== 4'h8) $display("FAIL dz_rem got=%h want=8", bus.REM); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dz_flag_hold got=%b want=1", bus.div_by_zero); else n_pass++;
    endtask

    task automatic test_extremes();
        int lat, nb; exp_t e;
        issue(8'hFF, 4'd1);
        wait_done(lat, nb);
        e = sb.pop_front();
        n_total++; if (bus.QUOT !== 8'd255 || bus.QUOT !== e.q) $display("FAIL ext_div1_quot got=%0d want=255", bus.QUOT); else n_pass++;
        n_total++; if (bus.REM !== 4'd0) $display("FAIL ext_div1_rem got=%0d want=0", bus.REM); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL ext_div1_dbz got=%b want=0", bus.div_by_zero); else n_pass++;
        issue(8'hFF, 4'hF);
        wait_done(lat, nb);
        e = sb.pop_front();
        n_total++; if (bus.QUOT !== 8'd17 || bus.QUOT !== e.q) $display("FAIL ext_div15_quot got=%0d want=17", bus.QUOT); else n_pass++;
        n_total++; if (bus.REM !== 4'd0) $display("FAIL ext_div15_rem got=%0d want=0", bus.REM); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int lat; exp_t e;
        issue(8'd100, 4'd7);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            bus.start = (lat == 2 || lat == 7);
            bus.DIVIDEND = 8'hFF; bus.DIVISOR = 4'd1;
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        n_total++; if (lat != e.lat) $display("FAIL ign_latency got=%0d want=%0d", lat, e.lat); else n_pass++;
        n_total++; if (bus.QUOT !== 8'd14) $display("FAIL ign_quot got=%0d want=14", bus.QUOT); else n_pass++;
        n_total++; if (bus.REM !== 4'd2) $display("FAIL ign_rem got=%0d want=2", bus.REM); else n_pass++;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL ign_done_start_busy got=%b want=0", bus.busy); else n_pass++;
        n_total++; if (bus.QUOT !== 8'd14) $display("FAIL ign_done_start_quot got=%0d want=14", bus.QUOT); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat, nb, seen; exp_t e;
        issue(8'd47, 4'd5);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        e = sb.pop_front();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_run_busy got=%b want=0", bus.busy); else n_pass++;
        n_total++; if (bus.QUOT !== '0) $display("FAIL rst_run_quot got=%0d want=0", bus.QUOT); else n_pass++;
        n_total++; if (bus.REM !== '0) $display("FAIL rst_run_rem got=%0d want=0", bus.REM); else n_pass++;
        seen = 0;
        repeat (DW + 4) begin
            if (bus.done === 1'b1) seen++;
            @(negedge clk);
        end
        n_total++; if (seen != 0) $display("FAIL rst_run_no_done got=%0d pulses want=0", seen); else n_pass++;
        issue(8'd150, 4'd11);
        wait_done(lat, nb);
        e = sb.pop_front();
        n_total++; if (lat != e.lat) $display("FAIL rst_after_latency got=%0d want=%0d", lat, e.lat); else n_pass++;
        n_total++; if (bus.QUOT !== 8'd13) $display("FAIL rst_after_quot got=%0d want=13", bus.QUOT); else n_pass++;
        n_total++; if (bus.REM !== 4'd7) $display("FAIL rst_after_rem got=%0d want=7", bus.REM); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, ndone, last;
        exp_t e;
        repeat (3) begin
            e.q = 8'd22; e.r = 4'd2; e.z = 1'b0; e.lat = DW;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b1; bus.DIVIDEND = 8'd200; bus.DIVISOR = 4'd9;
        cyc = 0; ndone = 0; last = 0;
        while (ndone < 3 && cyc < 3 * (DW + 2) + 10) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                e = sb.pop_front();
                ndone++;
                if (ndone == 3) bus.start = 1'b0;
                n_total++; if (bus.QUOT !== e.q || bus.REM !== e.r)
                    $display("FAIL b2b_result%0d got=%0d/%0d want=%0d/%0d", ndone, bus.QUOT, bus.REM, e.q, e.r);
                else n_pass++;
                if (ndone > 1) begin
                    n_total++; if (cyc - last != DW + 2) $display("FAIL b2b_spacing got=%0d want=%0d", cyc - last, DW + 2); else n_pass++;
                end
                last = cyc;
            end
        end
        bus.start = 1'b0;
        n_total++; if (ndone != 3) $display("FAIL b2b_count got=%0d want=3", ndone); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_trip();
        int lat, nb, errs; exp_t e;
        errs = 0;
        for (int b = 1; b <= 15; b++)
            for (int a = 1; a <= 15; a++)
                for (int c = 0; c < b; c++) begin
                    issue(DW'(a * b + c), W'(b));
                    wait_done(lat, nb);
                    e = sb.pop_front();
                    n_total++;
                    if (bus.QUOT !== DW'(a) || bus.REM !== W'(c) || bus.div_by_zero !== e.z || lat != e.lat) begin
                        errs++;
                        if (errs <= 10)
                            $display("FAIL rt_%0d_%0d_%0d got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=0 lat=%0d",
                                     a, b, c, bus.QUOT, bus.REM, bus.div_by_zero, lat, a, c, e.lat);
                    end else n_pass++;
                end
    endtask

    initial begin
        bus.start = 1'b0; bus.DIVIDEND = '0; bus.DIVISOR = '0;
        reset = 1'b1;
        test_reset();
        test_basic();
        test_div_zero();
        test_extremes();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_round_trip();
        n_total++; if (sb.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
